// File: rtl/adder_error_sweeper_if.sv
// Bus between the error sweeper and its controller/approximate adder.
// Carries the stimulus and response of the adder, the start/status handshake and the error metrics.
interface adder_error_sweeper_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
);
  logic                    start;
  logic [OUT_W-1:0]        approx_in;
  logic [IN_W-1:0]         stim_out;
  logic                    busy;
  logic                    done;
  logic [OUT_W-1:0]        max_err;
  logic [OUT_W+IN_W-1:0]   sum_err;
  logic [IN_W:0]           mism_cnt;
  logic                    fail_vld;
  logic [IN_W-1:0]         fail_vec;
  logic                    pass;

  modport master (
    output start, approx_in,
    input  stim_out, busy, done, max_err, sum_err, mism_cnt, fail_vld, fail_vec, pass
  );

  modport slave (
    input  start, approx_in,
    output stim_out, busy, done, max_err, sum_err, mism_cnt, fail_vld, fail_vec, pass
  );
endinterface

// File: rtl/adder_error_sweeper.sv
// Exhaustively drives an approximate adder and accumulates its error against the exact sum.
// Reports max/total error, mismatch count and the first vector whose error exceeds ET.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset, outputs zero, waiting for start
// S_SWEEP | one vector per cycle presented and its response scored
// S_DONE  | final metrics held; start launches a fresh sweep
module adder_error_sweeper #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_error_sweeper_if.slave  bus
);

  localparam int HALF = IN_W / 2;
  localparam int SUM_W = OUT_W + IN_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [OUT_W:0] ET_V = ET[OUT_W:0];

  logic [1:0]        state_q, state_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic [OUT_W-1:0]  max_err_q, max_err_d;
  logic [SUM_W-1:0]  sum_err_q, sum_err_d;
  logic [IN_W:0]     mism_cnt_q, mism_cnt_d;
  logic              fail_vld_q, fail_vld_d;
  logic [IN_W-1:0]   fail_vec_q, fail_vec_d;

  logic [HALF-1:0]   op_a, op_b;
  logic [OUT_W-1:0]  exact;
  logic [OUT_W-1:0]  err;
  logic              last_vec;

  // Ordered subtraction equals |approx - exact| truncated to OUT_W bits.
  always_comb begin
    op_a     = stim_q[HALF-1:0];
    op_b     = stim_q[IN_W-1:HALF];
    exact    = OUT_W'(op_a) + OUT_W'(op_b);
    err      = (bus.approx_in >= exact) ? (bus.approx_in - exact) : (exact - bus.approx_in);
    last_vec = (stim_q == {IN_W{1'b1}});
  end

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    max_err_d  = max_err_q;
    sum_err_d  = sum_err_q;
    mism_cnt_d = mism_cnt_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_SWEEP;
          stim_d     = '0;
          max_err_d  = '0;
          sum_err_d  = '0;
          mism_cnt_d = '0;
          fail_vld_d = 1'b0;
          fail_vec_d = '0;
        end
      end
      S_SWEEP: begin
        if (err > max_err_q) max_err_d = err;
        sum_err_d = sum_err_q + SUM_W'(err);
        if (err != '0) mism_cnt_d = mism_cnt_q + (IN_W+1)'(1);
        if (({1'b0, err} > ET_V) && !fail_vld_q) begin
          fail_vld_d = 1'b1;
          fail_vec_d = stim_q;
        end
        if (last_vec) state_d = S_DONE;
        else          stim_d  = stim_q + IN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      stim_q     <= '0;
      max_err_q  <= '0;
      sum_err_q  <= '0;
      mism_cnt_q <= '0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      max_err_q  <= max_err_d;
      sum_err_q  <= sum_err_d;
      mism_cnt_q <= mism_cnt_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign bus.stim_out = stim_q;
  assign bus.busy     = (state_q == S_SWEEP);
  assign bus.done     = (state_q == S_DONE);
  assign bus.max_err  = max_err_q;
  assign bus.sum_err  = sum_err_q;
  assign bus.mism_cnt = mism_cnt_q;
  assign bus.fail_vld = fail_vld_q;
  assign bus.fail_vec = fail_vec_q;
  assign bus.pass     = (state_q == S_DONE) & ~fail_vld_q;

endmodule

// File: tb/tb_adder_error_sweeper.sv
// Bench for adder_error_sweeper: three instances with ET = 7, 6, 3 share one start/reset and
// an adder model, so each sweep checks the same metrics against three thresholds.
module tb_adder_error_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_error_sweeper_if #(.IN_W(4), .OUT_W(3)) if7 ();
  adder_error_sweeper_if #(.IN_W(4), .OUT_W(3)) if6 ();
  adder_error_sweeper_if #(.IN_W(4), .OUT_W(3)) if3 ();

  adder_error_sweeper #(.IN_W(4), .OUT_W(3), .ET(7)) u7 (.clk(clk), .rst_n(rst_n), .bus(if7.slave));
  adder_error_sweeper #(.IN_W(4), .OUT_W(3), .ET(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
  adder_error_sweeper #(.IN_W(4), .OUT_W(3), .ET(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Approximate adder models: 0 exact, 1 stuck 0, 2 stuck 7, 3 exact^4, 4 exact+1
  function automatic logic [2:0] adder_model(input int m, input logic [3:0] s);
    logic [2:0] ex;
    ex = {1'b0, s[1:0]} + {1'b0, s[3:2]};
    case (m)
      0:       return ex;
      1:       return 3'd0;
      2:       return 3'd7;
      3:       return ex ^ 3'b100;
      default: return ex + 3'd1;
    endcase
  endfunction

  assign if7.start = start;
  assign if6.start = start;
  assign if3.start = start;
  assign if7.approx_in = adder_model(mode, if7.stim_out);
  assign if6.approx_in = adder_model(mode, if6.stim_out);
  assign if3.approx_in = adder_model(mode, if3.stim_out);

  typedef struct {
    int         mode;
    logic [2:0] max_err;
    logic [6:0] sum_err;
    logic [4:0] mism;
    logic [2:0] fv;      // bit0 ET7, bit1 ET6, bit2 ET3
    logic [3:0] fvec7;
    logic [3:0] fvec6;
    logic [3:0] fvec3;
  } vec_t;

  vec_t tbl[5];
  vec_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [2:0] mx, input logic [6:0] sm,
                         input logic [4:0] mi, input logic fv, input logic [3:0] fvec,
                         input logic ps, input logic dn, input vec_t e,
                         input logic efv, input logic [3:0] efvec);
    chk({nm, " done"}, dn, 1);
    chk({nm, " max_err"}, mx, e.max_err);
    chk({nm, " sum_err"}, sm, e.sum_err);
    chk({nm, " mism_cnt"}, mi, e.mism);
    chk({nm, " fail_vld"}, fv, efv);
    if (efv) chk({nm, " fail_vec"}, fvec, efvec);
    chk({nm, " pass"}, ps, !efv);
  endtask

  task automatic check_all(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk_res({tag, " et7"}, if7.max_err, if7.sum_err, if7.mism_cnt, if7.fail_vld, if7.fail_vec,
              if7.pass, if7.done, e, e.fv[0], e.fvec7);
      chk_res({tag, " et6"}, if6.max_err, if6.sum_err, if6.mism_cnt, if6.fail_vld, if6.fail_vec,
              if6.pass, if6.done, e, e.fv[1], e.fvec6);
      chk_res({tag, " et3"}, if3.max_err, if3.sum_err, if3.mism_cnt, if3.fail_vld, if3.fail_vec,
              if3.pass, if3.done, e, e.fv[2], e.fvec3);
    end
  endtask

  // Launch a sweep; returns after edge t0 with start released.
  task automatic launch(input vec_t e);
    mode = e.mode;
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (!if7.done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stim_out"}, if3.stim_out, 0);
    chk({tag, " busy"}, if3.busy, 0);
    chk({tag, " done"}, if3.done, 0);
    chk({tag, " max_err"}, if3.max_err, 0);
    chk({tag, " sum_err"}, if3.sum_err, 0);
    chk({tag, " mism_cnt"}, if3.mism_cnt, 0);
    chk({tag, " fail_vld"}, if3.fail_vld, 0);
    chk({tag, " fail_vec"}, if3.fail_vec, 0);
    chk({tag, " pass"}, if3.pass, 0);
  endtask

  initial begin
    int lat;
    tbl[0] = '{0, 3'd0, 7'd0,  5'd0,  3'b000, 4'd0, 4'd0, 4'd0};
    tbl[1] = '{1, 3'd6, 7'd48, 5'd15, 3'b100, 4'd0, 4'd0, 4'd7};
    tbl[2] = '{2, 3'd7, 7'd64, 5'd16, 3'b110, 4'd0, 4'd0, 4'd0};
    tbl[3] = '{3, 3'd4, 7'd64, 5'd16, 3'b100, 4'd0, 4'd0, 4'd0};
    tbl[4] = '{4, 3'd1, 7'd16, 5'd16, 3'b000, 4'd0, 4'd0, 4'd0};

    rst_n = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle busy", if7.busy, 0);

    for (int i = 0; i < 5; i++) begin
      launch(tbl[i]);
      chk($sformatf("v%0d busy_at_t0", i), if7.busy, 1);
      chk($sformatf("v%0d stim_at_t0", i), if7.stim_out, 0);
      wait_done(0, lat);
      chk($sformatf("v%0d latency", i), lat, 16);
      check_all($sformatf("v%0d", i));
      tick();
    end

    // start re-pulsed mid-sweep is ignored
    launch(tbl[2]);
    for (int c = 1; c < 5; c++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ignored busy", if6.busy, 1);
    chk("restart_ignored stim", if6.stim_out, 5);
    wait_done(5, lat);
    chk("restart_ignored latency", lat, 16);
    check_all("restart_ignored");

    // start in DONE clears accumulators and repeats
    launch(tbl[2]);
    chk("redo busy", if6.busy, 1);
    chk("redo done", if6.done, 0);
    chk("redo stim", if6.stim_out, 0);
    chk("redo max_err", if6.max_err, 0);
    chk("redo sum_err", if6.sum_err, 0);
    chk("redo mism_cnt", if6.mism_cnt, 0);
    chk("redo fail_vld", if6.fail_vld, 0);
    wait_done(0, lat);
    chk("redo latency", lat, 16);
    check_all("redo");

    // reset mid-sweep aborts
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk("pre_abort fail_vld_et3", if3.fail_vld, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("abort");
    for (int c = 0; c < 5; c++) tick();
    chk("post_abort busy", if3.busy, 0);
    chk("post_abort stim", if3.stim_out, 0);
    chk("post_abort done", if3.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_error_sweeper.md
# adder_error_sweeper

Sequential error-characterisation stage that sits directly downstream of a generated approximate adder (e.g. an `adder_i4_o3_*` netlist). It sweeps every input vector into the approximate adder and samples the adder's output. It compares that output against an internally computed exact sum and accumulates error metrics. It reports pass/fail against the error threshold (ET) used during synthesis.

## Interface
Parameters:
- `IN_W`, 4: total adder input bits. Must be even. Operand A = `stim_out[IN_W/2-1:0]`, operand B = `stim_out[IN_W-1:IN_W/2]`. Maps to `in0..in3` with `in0` as LSB.
- `OUT_W`, 3: approximate adder output bits (`out0` = LSB). Must equal `IN_W/2+1`.
- `ET`, 7: maximum allowed absolute error per vector.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE or DONE.
- `approx_in`, in, `OUT_W`: combinational response of the approximate adder to `stim_out`.
- `stim_out`, out, `IN_W`: registered stimulus to the approximate adder.
- `busy`, out, 1: high while in SWEEP.
- `done`, out, 1: high in DONE, held until next `start` or reset.
- `max_err`, out, `OUT_W`: largest |approx − exact| seen.
- `sum_err`, out, `OUT_W+IN_W`: sum of |approx − exact| over the sweep.
- `mism_cnt`, out, `IN_W+1`: number of vectors with nonzero error.
- `fail_vld`, out, 1: at least one vector had error > `ET`.
- `fail_vec`, out, `IN_W`: first vector with error > `ET`. Valid only when `fail_vld` is high.
- `pass`, out, 1: equals `done & ~fail_vld`.

## Operation
- States: IDLE, SWEEP, DONE.
- Reset (`rst_n`=0 at a clock edge) forces IDLE and zeroes every output: `stim_out`, `busy`, `done`, `max_err`, `sum_err`, `mism_cnt`, `fail_vld`, `fail_vec`, `pass`.
- IDLE or DONE with `start`=1 → SWEEP.
  - Clear all accumulators.
  - Clear `fail_vld`, `fail_vec` and `done`.
  - Set `stim_out` = 0.
- SWEEP, every cycle:
  - exact = A + B, zero-extended to `OUT_W` bits.
  - err = |`approx_in` − exact|, computed at `OUT_W+1` bits signed, then truncated to `OUT_W` bits.
  - `max_err` ← max(`max_err`, err).
  - `sum_err` ← `sum_err` + err. Width cannot overflow: 2^`IN_W` · (2^`OUT_W`−1) fits.
  - `mism_cnt` increments if err ≠ 0.
  - If err > `ET` and `fail_vld`=0: set `fail_vld`, latch `fail_vec` = `stim_out`.
  - If `stim_out` = 2^`IN_W`−1: go to DONE, leave `stim_out` unchanged.
  - Otherwise: `stim_out` increments.
- DONE: results held stable. `start` restarts the sweep as from IDLE.
- `start` during SWEEP is ignored. No restart and no accumulator disturbance.
- Reset mid-sweep aborts immediately to IDLE with all outputs zeroed. A new `start` is required.
- `approx_in` is don't-care outside SWEEP.

## Timing
- `start` sampled high at edge t0:
  - `busy`=1 and `stim_out`=0 after t0.
  - Vector k is presented after edge t0+k. Its `approx_in` is sampled at edge t0+k+1.
- The last vector (2^`IN_W`−1) is sampled at edge t0+2^`IN_W`. At that same edge: `busy`→0, `done`→1, final metrics are visible.
- Sweep latency: 2^`IN_W` cycles from `start` to `done` (16 for defaults).
- The external adder must settle within one clock period of a `stim_out` change. No pipeline register is allowed between `stim_out` and `approx_in`.
- A single-cycle `start` pulse is sufficient. A held `start` in DONE restarts every time DONE is entered, so the sweep repeats back-to-back.

## Test plan
- Exact adder model (`approx_in` = A+B), `start` pulse:
  - `done` 16 cycles later.
  - `max_err`=0, `sum_err`=0, `mism_cnt`=0, `fail_vld`=0, `pass`=1.
- `approx_in` held at 0:
  - `max_err`=6, `sum_err`=48, `mism_cnt`=15, `fail_vld`=0, `pass`=1 (ET=7).
- `approx_in` held at 7, ET=7:
  - `max_err`=7, `sum_err`=64, `mism_cnt`=16, `pass`=1.
  - Rerun with ET=6: `fail_vld`=1, `fail_vec`=0, `pass`=0.
- `approx_in` = exact XOR 3'b100:
  - `max_err`=4, `sum_err`=64, `mism_cnt`=16.
  - With ET=3: `fail_vec`=0.
- `start` re-pulsed at cycle 5 of a sweep:
  - Ignored; `done` still at cycle 16.
  - Then `start` in DONE: accumulators cleared the next cycle and the sweep repeats with identical results.
- `rst_n`=0 for one cycle at sweep cycle 8:
  - Next cycle: IDLE, all outputs 0.
  - No further activity until `start`.
